// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector: KMP-style progress FSM built from PATTERN at
// elaboration, selectable overlap and Mealy/Moore output, saturating match counter.
module seq_detector_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter bit             MOORE   = 1'b0,
    parameter int             CW      = 8,
    localparam int            SW      = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          A,
    input  logic          clear_count,
    output logic          Y,
    output logic [CW-1:0] match_count,
    output logic [SW-1:0] state
);

    // Length of the longest suffix of (prefix(k), b) that is also a prefix of PATTERN.
    function automatic int kmp_next(input int k, input int b);
        int   res;
        int   p;
        logic ok;
        logic sb;
        res = 0;
        for (int j = 1; j <= k + 1; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                p  = k + 1 - j + i;
                sb = (p < k) ? 1'(PATTERN >> (N - 1 - p)) : 1'(b);
                if (sb != 1'(PATTERN >> (N - 1 - i))) ok = 1'b0;
            end
            if (ok) res = j;
        end
        return res;
    endfunction

    function automatic int border_len();
        int   res;
        logic ok;
        res = 0;
        for (int j = 1; j < N; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (1'(PATTERN >> (N - 1 - i)) != 1'(PATTERN >> (j - 1 - i))) ok = 1'b0;
            end
            if (ok) res = j;
        end
        return res;
    endfunction

    localparam logic [SW-1:0] ST_B    = SW'(border_len());
    localparam logic [SW-1:0] ST_LAST = SW'(N - 1);
    localparam logic [SW-1:0] ST_N    = SW'(N);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [SW-1:0] tab0 [2**SW];
    logic [SW-1:0] tab1 [2**SW];

    for (genvar g = 0; g < 2**SW; g++) begin : g_tab
        if (g < N) begin : g_valid
            localparam int T0 = kmp_next(g, 0);
            localparam int T1 = kmp_next(g, 1);
            assign tab0[g] = SW'(T0);
            assign tab1[g] = SW'(T1);
        end else begin : g_pad
            assign tab0[g] = '0;
            assign tab1[g] = '0;
        end
    end

    logic [SW-1:0] state_next;
    logic [SW-1:0] base;
    logic          match_ev;
    logic          illegal;

    assign illegal = MOORE ? (state > ST_N) : (state > ST_LAST);

    always_comb begin
        state_next = state;
        match_ev   = 1'b0;
        base       = state;
        // Leaving the Moore match state behaves like leaving the restart point.
        if (MOORE && state == ST_N) base = OVERLAP ? ST_B : '0;
        if (illegal) begin
            state_next = '0;
        end else if (en) begin
            match_ev = (base == ST_LAST) && (A == PATTERN[0]);
            if (match_ev) begin
                if (MOORE) state_next = ST_N;
                else       state_next = OVERLAP ? ST_B : '0;
            end else begin
                state_next = A ? tab1[base] : tab0[base];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= '0;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                match_count <= '0;
        else if (clear_count)                      match_count <= '0;
        else if (match_ev && match_count != CNT_MAX) match_count <= match_count + CW'(1);
    end

    assign Y = MOORE ? (state == ST_N) : (match_ev & reset);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: four instances (Mealy overlap, Mealy non-overlap,
// Moore overlap, Mealy overlap with a 2-bit counter) share one input stream.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       a_bit = 1'b0;
    logic       clr = 1'b0;
    logic       clr_d = 1'b0;

    logic       y_a, y_b, y_c, y_d;
    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic [1:0] cnt_d;
    logic [2:0] st_a, st_b, st_c, st_d;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b0), .CW(8)) u_a (
        .clk(clk), .reset(reset), .en(en), .A(a_bit), .clear_count(clr),
        .Y(y_a), .match_count(cnt_a), .state(st_a));

    seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MOORE(1'b0), .CW(8)) u_b (
        .clk(clk), .reset(reset), .en(en), .A(a_bit), .clear_count(clr),
        .Y(y_b), .match_count(cnt_b), .state(st_b));

    seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b1), .CW(8)) u_c (
        .clk(clk), .reset(reset), .en(en), .A(a_bit), .clear_count(clr),
        .Y(y_c), .match_count(cnt_c), .state(st_c));

    seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b0), .CW(2)) u_d (
        .clk(clk), .reset(reset), .en(en), .A(a_bit), .clear_count(clr_d),
        .Y(y_d), .match_count(cnt_d), .state(st_d));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs just after an edge and let the combinational output settle.
    task automatic step(input logic a, input logic e);
        a_bit = a;
        en    = e;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic s2      [7] = '{1, 0, 1, 1, 0, 1, 1};
    int   ya2     [7] = '{0, 0, 0, 1, 0, 0, 1};
    int   yb2     [7] = '{0, 0, 0, 1, 0, 0, 0};
    int   yc2     [7] = '{0, 0, 0, 0, 1, 0, 0};
    int   sta2    [7] = '{1, 2, 3, 1, 2, 3, 1};
    int   stb2    [7] = '{1, 2, 3, 0, 0, 1, 1};
    int   stc2    [7] = '{1, 2, 3, 4, 2, 3, 4};
    int   cnta2   [7] = '{0, 0, 0, 1, 1, 1, 2};
    int   cntb2   [7] = '{0, 0, 0, 1, 1, 1, 1};

    logic s6a     [6] = '{1, 0, 0, 1, 1, 1};
    logic s6e     [6] = '{1, 1, 0, 1, 0, 1};
    int   ya6     [6] = '{0, 0, 0, 0, 0, 1};
    int   sta6    [6] = '{1, 2, 2, 3, 3, 1};
    int   stc6    [6] = '{1, 2, 2, 3, 3, 4};
    int   cnt6    [6] = '{0, 0, 0, 0, 0, 1};

    initial begin
        // Reset held from time zero
        tick();
        chk("rst st_a", st_a, 0);
        chk("rst cnt_a", cnt_a, 0);
        chk("rst y_c", y_c, 0);
        chk("rst st_c", st_c, 0);
        reset = 1'b1;
        tick();

        // Mealy/Moore, overlapping and non-overlapping on 1,0,1,1,0,1,1
        for (int i = 0; i < 7; i++) begin
            step(s2[i], 1'b1);
            chk($sformatf("s2 y_a bit%0d", i + 1), y_a, ya2[i]);
            chk($sformatf("s2 y_b bit%0d", i + 1), y_b, yb2[i]);
            chk($sformatf("s2 y_c bit%0d", i + 1), y_c, yc2[i]);
            tick();
            chk($sformatf("s2 st_a bit%0d", i + 1), st_a, sta2[i]);
            chk($sformatf("s2 st_b bit%0d", i + 1), st_b, stb2[i]);
            chk($sformatf("s2 st_c bit%0d", i + 1), st_c, stc2[i]);
            chk($sformatf("s2 cnt_a bit%0d", i + 1), cnt_a, cnta2[i]);
            chk($sformatf("s2 cnt_b bit%0d", i + 1), cnt_b, cntb2[i]);
            chk($sformatf("s2 cnt_c bit%0d", i + 1), cnt_c, cnta2[i]);
            chk($sformatf("s2 cnt_d bit%0d", i + 1), cnt_d, cnta2[i]);
        end

        // en low for three cycles: Moore flag persists, counters hold
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            chk("hold y_a", y_a, 0);
            chk("hold y_c", y_c, 1);
            tick();
            chk("hold st_c", st_c, 4);
            chk("hold cnt_c", cnt_c, 2);
            chk("hold st_a", st_a, 1);
            chk("hold cnt_a", cnt_a, 2);
        end

        // Overlapping repeats of 0,1,1: 2-bit counter saturates at 3
        for (int r = 1; r <= 5; r++) begin
            step(1'b0, 1'b1); tick();
            step(1'b1, 1'b1); tick();
            step(1'b1, 1'b1);
            chk("sat y_a", y_a, 1);
            tick();
            chk("sat cnt_a", cnt_a, 2 + r);
            chk("sat cnt_c", cnt_c, 2 + r);
            chk("sat cnt_d", cnt_d, (2 + r > 3) ? 3 : 2 + r);
            chk("sat st_d", st_d, 1);
        end

        // Clear coincident with a match wins; FSM unaffected
        step(1'b0, 1'b1); tick();
        step(1'b1, 1'b1); tick();
        step(1'b1, 1'b1);
        clr_d = 1'b1;
        tick();
        clr_d = 1'b0;
        chk("clr cnt_d", cnt_d, 0);
        chk("clr st_d", st_d, 1);
        chk("clr cnt_a", cnt_a, 8);
        step(1'b0, 1'b1); tick();
        step(1'b1, 1'b1); tick();
        step(1'b1, 1'b1); tick();
        chk("post clr cnt_d", cnt_d, 1);
        chk("post clr cnt_a", cnt_a, 9);

        // Asynchronous reset with a partial match in flight
        step(1'b0, 1'b1); tick();
        step(1'b1, 1'b1); tick();
        chk("pre rst st_a", st_a, 3);
        chk("pre rst st_c", st_c, 3);
        a_bit = 1'b1;
        reset = 1'b0;
        #1;
        chk("arst st_a", st_a, 0);
        chk("arst cnt_a", cnt_a, 0);
        chk("arst y_a", y_a, 0);
        chk("arst st_c", st_c, 0);
        chk("arst cnt_c", cnt_c, 0);
        chk("arst cnt_d", cnt_d, 0);
        tick();
        chk("in rst y_a", y_a, 0);
        chk("in rst st_a", st_a, 0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            chk("idle y_a", y_a, 0);
            tick();
            chk("idle st_a", st_a, 0);
            chk("idle cnt_a", cnt_a, 0);
            chk("idle y_c", y_c, 0);
        end

        // Gated input: disabled cycles carry junk and are ignored
        for (int i = 0; i < 6; i++) begin
            step(s6a[i], s6e[i]);
            chk($sformatf("gate y_a c%0d", i + 1), y_a, ya6[i]);
            tick();
            chk($sformatf("gate st_a c%0d", i + 1), st_a, sta6[i]);
            chk($sformatf("gate st_c c%0d", i + 1), st_c, stc6[i]);
            chk($sformatf("gate cnt_a c%0d", i + 1), cnt_a, cnt6[i]);
            chk($sformatf("gate cnt_d c%0d", i + 1), cnt_d, cnt6[i]);
        end
        chk("gate y_c", y_c, 1);
        chk("gate cnt_c", cnt_c, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial sequence detector. Each enabled clock it consumes one bit `A` and flags when the last `N` bits equal `PATTERN`. Overlapping or non-overlapping matching and Mealy or Moore output are selected by parameter. It keeps a saturating match counter and exposes its progress state for debug. It is the general serial-pattern detector for the digital lab designs; small fixed-pattern detectors become instances of it.

## Interface
- `N`, 4: pattern length in bits, 2..16.
- `PATTERN`, 4'b1011: `N`-bit pattern. `PATTERN[N-1]` is the first bit received; `PATTERN[0]` is the last.
- `OVERLAP`, 1: 1 means a match may reuse its own tail bits; 0 means detection restarts from scratch after a match.
- `MOORE`, 0: 0 gives a Mealy output (combinational, same cycle); 1 gives a Moore output (decoded from state, one cycle later).
- `CW`, 8: width of the match counter.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserted when 0.
- `en`  in  1  when 1, `A` is consumed this cycle; when 0, the FSM and counter hold.
- `A`  in  1  serial input bit.
- `clear_count`  in  1  synchronous clear of `match_count`.
- `Y`  out  1  match flag.
- `match_count`  out  CW  saturating count of matches.
- `state`  out  SW  current progress state, where SW = clog2(N+1).

## Operation
- The state value k is the number of pattern bits currently matched. It equals the length of the longest suffix of received bits that is also a prefix of `PATTERN`, i.e. `PATTERN[N-1 -: k]`.
- State range:
  - Mealy: 0..N-1.
  - Moore: 0..N. State N means "match".
- Transition on input bit b from state k < N (KMP rule):
  - next = largest j ≤ k+1 such that the last j bits of the sequence (prefix(k), b) equal prefix(j).
  - All transitions are derived from `PATTERN` at elaboration. No per-pattern hand coding.
- Let B be the length of the longest proper border of `PATTERN` (the longest proper prefix that is also a suffix).
- Match event: `en`=1, k = N-1 and `A` = `PATTERN[0]`.
- Mealy after a match: next state = B if `OVERLAP`=1, otherwise 0. `Y` = match event, purely combinational from `state`, `A` and `en`.
- Moore after a match: next state = N, and `Y` = (state == N). Leaving state N on bit b, the FSM takes the transition from state B if `OVERLAP`=1, or from state 0 if `OVERLAP`=0.
- `en`=0:
  - `state` and `match_count` hold.
  - Mealy `Y`=0.
  - Moore `Y` keeps reflecting the state, so it can stay high for several cycles while `en` is low. It still counts as one match.
- `match_count`:
  - Increments by 1 on the clock edge of each match event.
  - Saturates at 2^CW - 1.
  - `clear_count`=1 forces it to 0 and takes priority over a simultaneous match.
  - The FSM is not affected by `clear_count`.
- Any state encoding outside the legal range goes to state 0 on the next clock, with `Y`=0.

## Timing
- Reset (`reset`=0, asynchronous): `state`=0, `match_count`=0 and Moore `Y`=0 immediately.
  - Mealy `Y`=0 while in reset.
  - Release is sampled at the next rising edge of `clk`.
  - Reset in the middle of a partial match discards all progress.
- Mealy latency: `Y` is high in the same cycle the final pattern bit is present on `A` with `en`=1, before the clock edge.
- Moore latency: `Y` goes high for the cycle after the edge that consumed the final bit. That is one cycle later than Mealy.
- `match_count` updates on the same edge for both modes, so it is visible the cycle after the final bit.
- Back-to-back overlapping matches are separated by N-B enabled bits. No match is lost.

## Test plan
1. Reset and hold: `reset`=0 mid-stream with `state`=3 → `state`, `match_count` and `Y` all go to 0 asynchronously. After release with `en`=0 for 5 cycles, everything holds at 0.
2. Mealy, overlapping, `PATTERN`=1011, stream 1,0,1,1,0,1,1 with `en`=1 → `Y`=1 combinationally on bits 4 and 7 only. `match_count`=2. `state` after bit 4 is 1.
3. Mealy, non-overlapping, same stream → `Y`=1 on bit 4 only. `match_count`=1. `state` after bits 5,6,7 is 0,1,1.
4. Moore, overlapping, same stream → `Y` high during the cycles after bits 4 and 7, one cycle after the Mealy pulses. With `en` dropped for 3 cycles after bit 7, `Y` stays high and `match_count` stays 2.
5. Counter edges with `CW`=2 → seven matches give `match_count` sequence 1,2,3,3,3,3,3. `clear_count` asserted on the same cycle as a match gives `match_count`=0.
6. Gated input: stream 1,0,1,1 with `en`=0 on the cycle carrying the third bit and that bit's value flipped → the flipped bit is ignored, the match completes on the fourth enabled bit, and `Y` and the counter behave as in scenario 2.
